// File: rtl/irq_sched.sv
// Raster interrupt scheduler: counts HSYNC ends, requests a Z80 interrupt every 52 lines, resyncs to VSYNC.
// Optional status outputs INTCNT / VS_STATE are compiled in with IRQ_STATUS_EN.
module irq_sched (
    input  logic       CCLK,
    input  logic       RESET,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic       IORQ_n,
    input  logic       M1_n,
    input  logic       IRQ_RESET,
    output logic       INT_n,
    output logic       INT_EVENT
`ifdef IRQ_STATUS_EN
    ,
    output logic [5:0] INTCNT,
    output logic [1:0] VS_STATE
`endif
);

    typedef enum logic [1:0] {
        VS_IDLE  = 2'd0,
        VS_WAIT1 = 2'd1,
        VS_WAIT2 = 2'd2
    } vs_state_t;

    typedef enum logic {
        ACK_ARMED = 1'b0,
        ACK_HOLD  = 1'b1
    } ack_state_t;

    // Handshake: an acknowledge is one cycle with M1_n=0 and IORQ_n=0 while INT_n is low and
    // the ack FSM is ARMED; further acks are ignored until M1_n returns high.
    logic       hs_d;
    logic       vs_d;
    logic [5:0] intcnt;
    vs_state_t  vs_state;
    ack_state_t ack_state;

    logic       hend;
    logic       vstart;
    logic       resync;
    logic       ack;
    logic       raise;
    logic [5:0] cnt_next;

    always_comb begin
        hend     = hs_d & ~HSYNC;
        vstart   = ~vs_d & VSYNC;
        resync   = hend & ~vstart & (vs_state == VS_WAIT2);
        ack      = ~INT_n & ~M1_n & ~IORQ_n & (ack_state == ACK_ARMED);
        raise    = 1'b0;
        cnt_next = intcnt;
        if (resync) begin
            raise    = intcnt[5];
            cnt_next = 6'd0;
        end else if (hend) begin
            if (intcnt == 6'd51) begin
                raise    = 1'b1;
                cnt_next = 6'd0;
            end else begin
                cnt_next = intcnt + 6'd1;
            end
        end else if (ack) begin
            cnt_next = {1'b0, intcnt[4:0]};
        end
    end

    always_ff @(posedge CCLK) begin
        if (RESET) begin
            hs_d      <= 1'b0;
            vs_d      <= 1'b0;
            intcnt    <= 6'd0;
            INT_n     <= 1'b1;
            INT_EVENT <= 1'b0;
            vs_state  <= VS_IDLE;
            ack_state <= ACK_ARMED;
        end else begin
            hs_d      <= HSYNC;
            vs_d      <= VSYNC;
            INT_EVENT <= 1'b0;

            // VSTART outranks HEND; IRQ_RESET does not touch this FSM.
            if (vstart) begin
                vs_state <= VS_WAIT1;
            end else if (hend) begin
                case (vs_state)
                    VS_WAIT1: vs_state <= VS_WAIT2;
                    VS_WAIT2: vs_state <= VS_IDLE;
                    default:  vs_state <= vs_state;
                endcase
            end

            if (IRQ_RESET) begin
                intcnt <= 6'd0;
                INT_n  <= 1'b1;
            end else begin
                intcnt <= cnt_next;
                if (raise) begin
                    INT_n     <= 1'b0;
                    INT_EVENT <= INT_n;
                end else if (ack) begin
                    INT_n <= 1'b1;
                end
            end

            if (ack && !IRQ_RESET) begin
                ack_state <= ACK_HOLD;
            end else if (M1_n) begin
                ack_state <= ACK_ARMED;
            end
        end
    end

`ifdef IRQ_STATUS_EN
    assign INTCNT   = intcnt;
    assign VS_STATE = vs_state;
`endif

endmodule

// File: tb/tb_irq_sched.sv
// Bench for irq_sched: directed scenarios plus random traffic, checked every cycle against a line-count model.
module tb_irq_sched;

    logic CCLK = 1'b0;
    logic RESET, HSYNC, VSYNC, IORQ_n, M1_n, IRQ_RESET;
    logic INT_n, INT_EVENT;
`ifdef IRQ_STATUS_EN
    logic [5:0] INTCNT;
    logic [1:0] VS_STATE;
`endif

    irq_sched dut (
        .CCLK      (CCLK),
        .RESET     (RESET),
        .HSYNC     (HSYNC),
        .VSYNC     (VSYNC),
        .IORQ_n    (IORQ_n),
        .M1_n      (M1_n),
        .IRQ_RESET (IRQ_RESET),
        .INT_n     (INT_n),
        .INT_EVENT (INT_EVENT)
`ifdef IRQ_STATUS_EN
        ,
        .INTCNT    (INTCNT),
        .VS_STATE  (VS_STATE)
`endif
    );

    always #5 CCLK = ~CCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: lines counted as an integer, VSYNC delay as "line ends still to wait".
    int m_cnt, m_left, n_cnt, n_left;
    bit m_int_n, m_evt, m_hold, m_hs, m_vs;
    bit n_int_n, n_evt, n_hold;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit hend, vstart, ack, raise, resync;
        hend   = m_hs && !HSYNC;
        vstart = !m_vs && VSYNC;
        ack    = !m_int_n && !M1_n && !IORQ_n && !m_hold;
        raise  = 0;
        resync = 0;
        n_cnt = m_cnt; n_left = m_left; n_int_n = m_int_n; n_evt = 0; n_hold = m_hold;
        if (vstart) n_left = 2;
        else if (hend && m_left == 2) n_left = 1;
        else if (hend && m_left == 1) begin n_left = 0; resync = 1; end
        if (RESET) begin
            n_cnt = 0; n_left = 0; n_int_n = 1; n_hold = 0;
        end else if (IRQ_RESET) begin
            n_cnt = 0; n_int_n = 1;
            if (M1_n) n_hold = 0;
        end else begin
            if (resync) begin
                raise = (m_cnt >= 32);
                n_cnt = 0;
            end else if (hend) begin
                if (m_cnt + 1 == 52) begin n_cnt = 0; raise = 1; end
                else n_cnt = m_cnt + 1;
            end else if (ack) begin
                n_cnt = (m_cnt >= 32) ? m_cnt - 32 : m_cnt;
            end
            n_evt = raise && m_int_n;
            if (raise) n_int_n = 0;
            else if (ack) n_int_n = 1;
            if (ack) n_hold = 1;
            else if (M1_n) n_hold = 0;
        end
        m_hs = RESET ? 1'b0 : HSYNC;
        m_vs = RESET ? 1'b0 : VSYNC;
    endtask

    task automatic tick();
        int exp_vs;
        model_step();
        @(posedge CCLK);
        #1;
        m_cnt = n_cnt; m_left = n_left; m_int_n = n_int_n; m_evt = n_evt; m_hold = n_hold;
        exp_vs = (m_left == 2) ? 1 : (m_left == 1) ? 2 : 0;
        check("int_n", int'(INT_n), int'(m_int_n));
        check("int_event", int'(INT_EVENT), int'(m_evt));
        check("intcnt", int'(dut.intcnt), m_cnt);
        check("vs_state", int'(dut.vs_state), exp_vs);
        check("ack_state", int'(dut.ack_state), int'(m_hold));
`ifdef IRQ_STATUS_EN
        check("INTCNT_port", int'(INTCNT), m_cnt);
        check("VS_STATE_port", int'(VS_STATE), exp_vs);
`endif
    endtask

    task automatic hs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            HSYNC = 1'b1; tick();
            HSYNC = 1'b0; tick();
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; tick(); RESET = 1'b0;
    endtask

    initial begin
        int evt_seen;
        m_cnt = 0; m_left = 0; m_int_n = 1; m_evt = 0; m_hold = 0; m_hs = 0; m_vs = 0;
        RESET = 1'b1; HSYNC = 1'b0; VSYNC = 1'b0; IORQ_n = 1'b1; M1_n = 1'b1; IRQ_RESET = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        check("reset_int_n", int'(INT_n), 1);
        check("reset_evt", int'(INT_EVENT), 0);
        check("reset_cnt", int'(dut.intcnt), 0);

        // 52 lines -> one interrupt, one event pulse, counter wrapped.
        evt_seen = 0;
        for (int i = 0; i < 51; i++) begin
            HSYNC = 1'b1; tick(); evt_seen += int'(INT_EVENT);
            HSYNC = 1'b0; tick(); evt_seen += int'(INT_EVENT);
        end
        check("l51_int_n", int'(INT_n), 1);
        check("l51_cnt", int'(dut.intcnt), 51);
        HSYNC = 1'b1; tick();
        HSYNC = 1'b0; tick(); evt_seen += int'(INT_EVENT);
        check("l52_int_n", int'(INT_n), 0);
        check("l52_cnt", int'(dut.intcnt), 0);
        tick(); evt_seen += int'(INT_EVENT);
        check("l52_evt_count", evt_seen, 1);

        // Acknowledge held for 3 cycles: only the first is taken.
        M1_n = 1'b0; IORQ_n = 1'b0;
        tick();
        check("ack_int_n", int'(INT_n), 1);
        check("ack_hold", int'(dut.ack_state), 1);
        tick(); tick();
        check("ack_hold2", int'(dut.ack_state), 1);
        M1_n = 1'b1; IORQ_n = 1'b1;
        tick();
        check("ack_armed", int'(dut.ack_state), 0);

        // VSYNC resync with count 40 -> interrupt.
        do_reset();
        hs_pulses(40);
        VSYNC = 1'b1; tick();
        check("vs_wait1", int'(dut.vs_state), 1);
        hs_pulses(1);
        check("vs_wait2", int'(dut.vs_state), 2);
        hs_pulses(1);
        check("rs40_int_n", int'(INT_n), 0);
        check("rs40_cnt", int'(dut.intcnt), 0);
        check("rs40_idle", int'(dut.vs_state), 0);
        VSYNC = 1'b0;

        // VSYNC resync with count 20 -> no interrupt.
        do_reset();
        hs_pulses(20);
        VSYNC = 1'b1; tick();
        hs_pulses(2);
        check("rs20_int_n", int'(INT_n), 1);
        check("rs20_cnt", int'(dut.intcnt), 0);
        VSYNC = 1'b0;

        // IRQ_RESET coincident with the wrapping line end.
        do_reset();
        hs_pulses(51);
        HSYNC = 1'b1; tick();
        HSYNC = 1'b0; IRQ_RESET = 1'b1; tick();
        IRQ_RESET = 1'b0;
        check("irqr_cnt", int'(dut.intcnt), 0);
        check("irqr_int_n", int'(INT_n), 1);
        check("irqr_evt", int'(INT_EVENT), 0);

        // Ack coincident with the 52nd line end while INT_n is already low.
        do_reset();
        hs_pulses(40);
        VSYNC = 1'b1; tick();
        hs_pulses(2);
        VSYNC = 1'b0;
        check("pre_ack_int_n", int'(INT_n), 0);
        hs_pulses(51);
        HSYNC = 1'b1; tick();
        HSYNC = 1'b0; M1_n = 1'b0; IORQ_n = 1'b0; tick();
        check("ackraise_int_n", int'(INT_n), 0);
        check("ackraise_cnt", int'(dut.intcnt), 0);
        check("ackraise_evt", int'(INT_EVENT), 0);
        M1_n = 1'b1; IORQ_n = 1'b1; tick();

        // RESET while waiting for the resync line with INT_n low.
        do_reset();
        hs_pulses(52);
        VSYNC = 1'b1; tick();
        hs_pulses(1);
        check("pre_rst_wait2", int'(dut.vs_state), 2);
        check("pre_rst_int_n", int'(INT_n), 0);
        RESET = 1'b1; IRQ_RESET = 1'b1; tick();
        RESET = 1'b0; IRQ_RESET = 1'b0; VSYNC = 1'b0;
        check("rst_int_n", int'(INT_n), 1);
        check("rst_cnt", int'(dut.intcnt), 0);
        check("rst_vs", int'(dut.vs_state), 0);
        check("rst_ack", int'(dut.ack_state), 0);
        hs_pulses(1);
        check("post_rst_cnt", int'(dut.intcnt), 1);
        check("post_rst_int_n", int'(INT_n), 1);

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) HSYNC = ~HSYNC;
            if ($urandom_range(0, 150) == 0) VSYNC = ~VSYNC;
            M1_n      = ($urandom_range(0, 3) != 0);
            IORQ_n    = ($urandom_range(0, 2) != 0);
            IRQ_RESET = ($urandom_range(0, 400) == 0);
            RESET     = ($urandom_range(0, 2500) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
